// File: rtl/game_flow_ctrl_pkg.sv
// Shared types and constants for the game flow sequencer: state encodings,
// default point values, the lives type and a saturating score adder.
package game_flow_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT = 3'd0,
    ST_READY   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_DYING   = 3'd3,
    ST_CLEAR   = 3'd4,
    ST_OVER    = 3'd5
  } state_e;

  typedef logic [2:0] lives_t;

  localparam int unsigned PELLET_PTS_DEF = 10;
  localparam int unsigned POWER_PTS_DEF  = 50;
  localparam int unsigned GHOST_PTS_DEF  = 200;

  // Score never wraps; anything past 16'hFFFF pins at the top.
  function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [17:0] inc);
    logic [17:0] sum;
    sum = {2'b00, base} + inc;
    return (sum > 18'h0FFFF) ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Event inputs and status outputs of the game flow sequencer, bundled so the
// top level can route them between crash checker, movers and display.
interface game_flow_ctrl_if;
  import game_flow_ctrl_pkg::*;

  logic        tick;
  logic        start;
  logic        crash;
  logic        pellet_eaten;
  logic        power_eaten;
  logic        maze_empty;

  state_e      state;
  logic        pac_move_en;
  logic        ghost_move_en;
  logic        frightened;
  logic        respawn;
  logic        ghost_home;
  lives_t      lives;
  logic [3:0]  level;
  logic [15:0] score;
  logic        over;

  modport master (
    output tick, start, crash, pellet_eaten, power_eaten, maze_empty,
    input  state, pac_move_en, ghost_move_en, frightened, respawn,
           ghost_home, lives, level, score, over
  );

  modport slave (
    input  tick, start, crash, pellet_eaten, power_eaten, maze_empty,
    output state, pac_move_en, ghost_move_en, frightened, respawn,
           ghost_home, lives, level, score, over
  );

endinterface

// File: rtl/game_flow_ctrl_tick_divider.sv
// Frame-tick divider producing a registered one-cycle movement strobe every
// DIV ticks (2*DIV when div_sel_i is high); held at zero while disabled.
module game_flow_ctrl_tick_divider #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic tick_i,
  input  logic div_sel_i,
  output logic strobe_o
);

  localparam logic [15:0] LIM_NORM = 16'(DIV);
  localparam logic [15:0] LIM_SLOW = 16'(2 * DIV);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] limit;
  logic        strobe_q, strobe_d;

  // Compare with >= so a limit that shrinks mid-count still wraps cleanly.
  always_comb begin
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    limit    = div_sel_i ? LIM_SLOW : LIM_NORM;
    if (!en_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q + 16'd1 >= limit) begin
        cnt_d    = '0;
        strobe_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Pacman round sequencer: owns attract/ready/play/dying/clear/over flow,
// score, lives, level, frightened mode and the movement enables.
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter lives_t      LIVES_INIT   = 3'd3,
  parameter int unsigned READY_TICKS  = 120,
  parameter int unsigned DYING_TICKS  = 90,
  parameter int unsigned FRIGHT_TICKS = 360,
  parameter int unsigned PAC_DIV      = 2,
  parameter int unsigned GHOST_DIV    = 3,
  parameter int unsigned PELLET_PTS   = PELLET_PTS_DEF,
  parameter int unsigned POWER_PTS    = POWER_PTS_DEF,
  parameter int unsigned GHOST_PTS    = GHOST_PTS_DEF
) (
  input logic             clk_i,
  input logic             rst_ni,
  game_flow_ctrl_if.slave bus
);

  state_e      state_q;
  logic [15:0] tick_cnt_q;
  logic [15:0] fright_cnt_q;
  logic [15:0] score_q;
  lives_t      lives_q;
  logic [3:0]  level_q;
  logic        frightened_q;
  logic        over_q;
  logic        respawn_q;
  logic        ghost_home_q;
  logic        crash_prev_q;
  logic        start_prev_q;

  logic        crash_rise;
  logic        start_rise;
  logic        ready_done;
  logic        dying_done;
  logic        play_en;
  logic [17:0] score_inc;
  logic [15:0] score_d;
  logic        pac_strobe;
  logic        ghost_strobe;

  always_comb begin
    crash_rise = bus.crash & ~crash_prev_q;
    start_rise = bus.start & ~start_prev_q;
    play_en    = (state_q == ST_PLAY);
    ready_done = bus.tick && (tick_cnt_q == 16'(READY_TICKS - 1));
    dying_done = bus.tick && (tick_cnt_q == 16'(DYING_TICKS - 1));
    score_inc  = '0;
    if (bus.pellet_eaten) score_inc = score_inc + 18'(PELLET_PTS);
    if (bus.power_eaten)  score_inc = score_inc + 18'(POWER_PTS);
    if (crash_rise && frightened_q) score_inc = score_inc + 18'(GHOST_PTS);
    score_d = sat_add16(score_q, score_inc);
  end

  // Every state change clears tick_cnt_q, so the tick that causes a
  // transition is never counted toward the next state's duration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_ATTRACT;
      tick_cnt_q   <= '0;
      fright_cnt_q <= '0;
      score_q      <= '0;
      lives_q      <= LIVES_INIT;
      level_q      <= '0;
      frightened_q <= 1'b0;
      over_q       <= 1'b0;
      respawn_q    <= 1'b0;
      ghost_home_q <= 1'b0;
      crash_prev_q <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      respawn_q    <= 1'b0;
      ghost_home_q <= 1'b0;
      crash_prev_q <= bus.crash;
      start_prev_q <= bus.start;

      case (state_q)
        ST_ATTRACT: begin
          if (start_rise) begin
            score_q      <= '0;
            lives_q      <= LIVES_INIT;
            level_q      <= '0;
            frightened_q <= 1'b0;
            fright_cnt_q <= '0;
            respawn_q    <= 1'b1;
            tick_cnt_q   <= '0;
            state_q      <= ST_READY;
          end
        end

        ST_READY: begin
          if (ready_done) begin
            tick_cnt_q <= '0;
            state_q    <= ST_PLAY;
          end else if (bus.tick) begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
          end
        end

        ST_PLAY: begin
          score_q <= score_d;
          if (bus.power_eaten) begin
            frightened_q <= 1'b1;
            fright_cnt_q <= 16'(FRIGHT_TICKS);
          end else if (frightened_q && bus.tick) begin
            if (fright_cnt_q <= 16'd1) begin
              frightened_q <= 1'b0;
              fright_cnt_q <= '0;
            end else begin
              fright_cnt_q <= fright_cnt_q - 16'd1;
            end
          end

          if (crash_rise && frightened_q) begin
            ghost_home_q <= 1'b1;
          end

          // A fatal crash outranks both a same-cycle power pellet and maze_empty.
          if (crash_rise && !frightened_q) begin
            if (lives_q != '0) lives_q <= lives_q - 3'd1;
            frightened_q <= 1'b0;
            fright_cnt_q <= '0;
            tick_cnt_q   <= '0;
            state_q      <= ST_DYING;
          end else if (bus.maze_empty) begin
            tick_cnt_q <= '0;
            state_q    <= ST_CLEAR;
          end
        end

        ST_DYING: begin
          if (dying_done) begin
            tick_cnt_q <= '0;
            if (lives_q == '0) begin
              over_q  <= 1'b1;
              state_q <= ST_OVER;
            end else begin
              respawn_q <= 1'b1;
              state_q   <= ST_READY;
            end
          end else if (bus.tick) begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
          end
        end

        ST_CLEAR: begin
          if (ready_done) begin
            if (level_q != 4'hF) level_q <= level_q + 4'd1;
            frightened_q <= 1'b0;
            fright_cnt_q <= '0;
            respawn_q    <= 1'b1;
            tick_cnt_q   <= '0;
            state_q      <= ST_READY;
          end else if (bus.tick) begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
          end
        end

        ST_OVER: begin
          over_q <= 1'b1;
          if (start_rise) begin
            over_q     <= 1'b0;
            tick_cnt_q <= '0;
            state_q    <= ST_ATTRACT;
          end
        end

        default: begin
          over_q     <= 1'b0;
          tick_cnt_q <= '0;
          state_q    <= ST_ATTRACT;
        end
      endcase
    end
  end

  game_flow_ctrl_tick_divider #(.DIV(PAC_DIV)) u_pac_div (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (play_en),
    .tick_i    (bus.tick),
    .div_sel_i (1'b0),
    .strobe_o  (pac_strobe)
  );

  game_flow_ctrl_tick_divider #(.DIV(GHOST_DIV)) u_ghost_div (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (play_en),
    .tick_i    (bus.tick),
    .div_sel_i (frightened_q),
    .strobe_o  (ghost_strobe)
  );

  assign bus.state         = state_q;
  assign bus.pac_move_en   = pac_strobe;
  assign bus.ghost_move_en = ghost_strobe;
  assign bus.frightened    = frightened_q;
  assign bus.respawn       = respawn_q;
  assign bus.ghost_home    = ghost_home_q;
  assign bus.lives         = lives_q;
  assign bus.level         = level_q;
  assign bus.score         = score_q;
  assign bus.over          = over_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: stimulus queues expected values, a
// negedge monitor pops and compares them against the DUT and pulse tallies.
module tb_game_flow_ctrl;
  import game_flow_ctrl_pkg::*;

  localparam int SEL_STATE = 0, SEL_LIVES = 1, SEL_LEVEL = 2, SEL_SCORE = 3;
  localparam int SEL_OVER = 4, SEL_FRIGHT = 5, SEL_PAC = 6, SEL_GHOST = 7;
  localparam int SEL_RESPAWN = 8, SEL_HOME = 9, SEL_CLR = 10;

  typedef struct {
    string       name;
    int          sel;
    int unsigned exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  game_flow_ctrl_if bus ();

  game_flow_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   pac_seen = 0, ghost_seen = 0, respawn_seen = 0, home_seen = 0;

  function automatic int unsigned probe(int sel);
    case (sel)
      SEL_STATE:   return int'(bus.state);
      SEL_LIVES:   return int'(bus.lives);
      SEL_LEVEL:   return int'(bus.level);
      SEL_SCORE:   return int'(bus.score);
      SEL_OVER:    return int'(bus.over);
      SEL_FRIGHT:  return int'(bus.frightened);
      SEL_PAC:     return pac_seen;
      SEL_GHOST:   return ghost_seen;
      SEL_RESPAWN: return respawn_seen;
      SEL_HOME:    return home_seen;
      default:     return 0;
    endcase
  endfunction

  // Monitor: tally strobes, then settle every pending expectation.
  always @(negedge clk) begin : mon_blk
    exp_t        e;
    int unsigned act;
    if (bus.pac_move_en)   pac_seen++;
    if (bus.ghost_move_en) ghost_seen++;
    if (bus.respawn)       respawn_seen++;
    if (bus.ghost_home)    home_seen++;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel == SEL_CLR) begin
        pac_seen = 0; ghost_seen = 0; respawn_seen = 0; home_seen = 0;
      end else begin
        act = probe(e.sel);
        total_cnt++;
        if (act == e.exp) begin
          pass_cnt++;
          $display("[%0t] chk %-18s got %0d exp %0d ok", $time, e.name, act, e.exp);
        end else begin
          $display("[%0t] FAIL %s: got %0d, expected %0d", $time, e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input string n, input int sel, input int unsigned v);
    sb_q.push_back('{n, sel, v});
  endtask

  task automatic clr_counts();
    sb_q.push_back('{"clr", SEL_CLR, 0});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit reached, summary %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    bus.tick = 0; bus.start = 0; bus.crash = 0;
    bus.pellet_eaten = 0; bus.power_eaten = 0; bus.maze_empty = 0;
    step();
    expect_val("rst_state", SEL_STATE, ST_ATTRACT);
    expect_val("rst_lives", SEL_LIVES, 3);
    expect_val("rst_level", SEL_LEVEL, 0);
    expect_val("rst_score", SEL_SCORE, 0);
    expect_val("rst_over", SEL_OVER, 0);
    expect_val("rst_fright", SEL_FRIGHT, 0);
    step();
    rst_ni = 1'b1;
    step();

    // start -> single respawn pulse, READY; scoring ignored outside PLAY
    clr_counts();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    expect_val("start_respawn", SEL_RESPAWN, 1);
    expect_val("start_state", SEL_STATE, ST_READY);
    bus.pellet_eaten = 1'b1;
    step();
    bus.pellet_eaten = 1'b0;
    step();
    expect_val("ready_no_score", SEL_SCORE, 0);
    clr_counts();
    do_ticks(119);
    expect_val("ready_119", SEL_STATE, ST_READY);
    expect_val("ready_no_pac", SEL_PAC, 0);
    do_ticks(1);
    expect_val("ready_120", SEL_STATE, ST_PLAY);
    expect_val("play_score", SEL_SCORE, 0);
    expect_val("play_lives", SEL_LIVES, 3);

    // movement dividers
    clr_counts();
    do_ticks(12);
    expect_val("pac_12t", SEL_PAC, 6);
    expect_val("ghost_12t", SEL_GHOST, 4);

    // pellet + power same cycle, frightened ghost rate
    bus.pellet_eaten = 1'b1; bus.power_eaten = 1'b1;
    step();
    bus.pellet_eaten = 1'b0; bus.power_eaten = 1'b0;
    expect_val("both_score", SEL_SCORE, 60);
    expect_val("both_fright", SEL_FRIGHT, 1);
    clr_counts();
    do_ticks(12);
    expect_val("fr_ghost_12t", SEL_GHOST, 2);
    expect_val("fr_pac_12t", SEL_PAC, 6);

    // crash while frightened
    clr_counts();
    bus.crash = 1'b1;
    step();
    bus.crash = 1'b0;
    step();
    expect_val("eat_score", SEL_SCORE, 260);
    expect_val("eat_home", SEL_HOME, 1);
    expect_val("eat_state", SEL_STATE, ST_PLAY);
    do_ticks(347);
    expect_val("fr_359", SEL_FRIGHT, 1);
    do_ticks(1);
    expect_val("fr_360", SEL_FRIGHT, 0);

    // climb to 65530, then saturate
    bus.power_eaten = 1'b1;
    repeat (1305) step();
    bus.power_eaten = 1'b0;
    bus.pellet_eaten = 1'b1;
    step();
    step();
    bus.pellet_eaten = 1'b0;
    step();
    expect_val("score_65530", SEL_SCORE, 65530);
    bus.pellet_eaten = 1'b1;
    step();
    bus.pellet_eaten = 1'b0;
    step();
    expect_val("score_sat", SEL_SCORE, 65535);
    bus.pellet_eaten = 1'b1;
    step();
    bus.pellet_eaten = 1'b0;
    step();
    expect_val("score_nowrap", SEL_SCORE, 65535);
    do_ticks(360);
    expect_val("fr_clear2", SEL_FRIGHT, 0);

    // fatal crash held high: one death only
    clr_counts();
    bus.crash = 1'b1;
    step();
    step();
    step();
    bus.crash = 1'b0;
    expect_val("death1_lives", SEL_LIVES, 2);
    expect_val("death1_state", SEL_STATE, ST_DYING);
    do_ticks(89);
    expect_val("dying_89", SEL_STATE, ST_DYING);
    do_ticks(1);
    expect_val("dying_90", SEL_STATE, ST_READY);
    expect_val("dying_respawn", SEL_RESPAWN, 1);
    do_ticks(120);

    // crash beats maze_empty
    bus.maze_empty = 1'b1; bus.crash = 1'b1;
    step();
    bus.maze_empty = 1'b0; bus.crash = 1'b0;
    step();
    expect_val("prio_state", SEL_STATE, ST_DYING);
    expect_val("prio_lives", SEL_LIVES, 1);
    do_ticks(90);
    do_ticks(120);
    expect_val("replay_state", SEL_STATE, ST_PLAY);

    // level clear
    bus.maze_empty = 1'b1;
    step();
    bus.maze_empty = 1'b0;
    step();
    expect_val("clear_state", SEL_STATE, ST_CLEAR);
    clr_counts();
    do_ticks(119);
    expect_val("clear_level0", SEL_LEVEL, 0);
    do_ticks(1);
    expect_val("clear_ready", SEL_STATE, ST_READY);
    expect_val("clear_level1", SEL_LEVEL, 1);
    expect_val("clear_respawn", SEL_RESPAWN, 1);
    do_ticks(120);

    // last life
    bus.crash = 1'b1;
    step();
    bus.crash = 1'b0;
    step();
    expect_val("death3_lives", SEL_LIVES, 0);
    do_ticks(90);
    expect_val("over_state", SEL_STATE, ST_OVER);
    expect_val("over_flag", SEL_OVER, 1);
    expect_val("over_score", SEL_SCORE, 65535);
    expect_val("over_level", SEL_LEVEL, 1);

    // start held across OVER -> ATTRACT must not restart
    bus.start = 1'b1;
    step();
    expect_val("restart_attract", SEL_STATE, ST_ATTRACT);
    expect_val("restart_over0", SEL_OVER, 0);
    step();
    step();
    expect_val("held_attract", SEL_STATE, ST_ATTRACT);
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    expect_val("newgame_state", SEL_STATE, ST_READY);
    expect_val("newgame_score", SEL_SCORE, 0);
    expect_val("newgame_lives", SEL_LIVES, 3);
    expect_val("newgame_level", SEL_LEVEL, 0);

    // async reset mid-PLAY
    do_ticks(120);
    bus.pellet_eaten = 1'b1; bus.power_eaten = 1'b1;
    step();
    bus.pellet_eaten = 1'b0; bus.power_eaten = 1'b0;
    expect_val("pre_rst_score", SEL_SCORE, 60);
    expect_val("pre_rst_fright", SEL_FRIGHT, 1);
    step();
    rst_ni = 1'b0;
    expect_val("mid_rst_state", SEL_STATE, ST_ATTRACT);
    expect_val("mid_rst_score", SEL_SCORE, 0);
    expect_val("mid_rst_fright", SEL_FRIGHT, 0);
    expect_val("mid_rst_lives", SEL_LIVES, 3);
    step();
    rst_ni = 1'b1;
    step();
    step();

    if (sb_q.size() != 0)
      $display("FAIL scoreboard: %0d expectations never settled", sb_q.size());
    if (total_cnt < 12)
      $display("FAIL coverage: only %0d checks evaluated", total_cnt);
    if (pass_cnt == total_cnt && total_cnt >= 12 && sb_q.size() == 0)
      $display("PASS %0d/%0d checks passed", pass_cnt, total_cnt);
    else
      $display("FAIL %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Central sequencer for the Pacman game. Owns round state: attract, ready countdown, play, death, level clear, game over.
- Gates the pacman and ghost movement engines with enable pulses derived from a frame tick.
- Accumulates score and lives, arbitrates crash events (death vs. ghost eaten), and drives the game-over flag to the display and the 7-segment path.
- Sits in the top level between the crash checker, key control, ghost movers and the display.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..7)
- READY_TICKS, 120, frame ticks spent in READY and CLEAR
- DYING_TICKS, 90, frame ticks spent in DYING
- FRIGHT_TICKS, 360, frame ticks the frightened mode lasts after a power pellet
- PAC_DIV, 2, pac_move_en fires every PAC_DIV ticks in PLAY
- GHOST_DIV, 3, ghost_move_en fires every GHOST_DIV ticks in PLAY (every 2*GHOST_DIV while frightened)
- PELLET_PTS, 10; POWER_PTS, 50; GHOST_PTS, 200, score increments

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle frame pulse, synchronous to clk
- start  in  1  start/restart request (level, already debounced)
- crash  in  1  pacman/ghost overlap (level)
- pellet_eaten  in  1  one-cycle pulse
- power_eaten  in  1  one-cycle pulse
- maze_empty  in  1  no pellets left (level)
- state  out  3  current state encoding
- pac_move_en  out  1  one-cycle movement strobe
- ghost_move_en  out  1  one-cycle movement strobe
- frightened  out  1  ghosts in frightened mode
- respawn  out  1  one-cycle pulse: reset actor positions
- ghost_home  out  1  one-cycle pulse: eaten ghost returns home
- lives  out  3  remaining lives
- level  out  4  current level, starts at 0
- score  out  16  binary score
- over  out  1  game over

Behaviour:
- Reset (rst=0, async):
  - state=ATTRACT, lives=LIVES_INIT, level=0, score=0.
  - All strobes and frightened = 0; over = 0; all counters = 0.
- States: ATTRACT=0, READY=1, PLAY=2, DYING=3, CLEAR=4, OVER=5. Encodings 6 and 7 recover to ATTRACT on the next clk.
- ATTRACT:
  - On start=1: load score=0, lives=LIVES_INIT, level=0.
  - Pulse respawn for 1 cycle, then go to READY.
- READY:
  - Count READY_TICKS ticks, then go to PLAY.
  - No strobes are issued.
- PLAY:
  - Tick divider counters run only here. A strobe is asserted in the same cycle as the tick that makes the counter reach its divide value; the counter then wraps to 0.
  - Frightened divider uses 2*GHOST_DIV.
- Scoring:
  - Evaluated every clk in PLAY only; events are ignored in other states.
  - pellet_eaten adds PELLET_PTS; power_eaten adds POWER_PTS.
  - Both events in the same cycle add the sum.
  - score saturates at 16'hFFFF, with no wrap.
- Power pellet:
  - Sets frightened=1 and loads the fright counter with FRIGHT_TICKS.
  - A power pellet arriving while already frightened reloads the counter.
  - The counter decrements on tick; frightened clears when it reaches 0.
- Crash handling (PLAY only; crash is edge-detected, acting on the rising edge only):
  - If frightened: add GHOST_PTS, pulse ghost_home, stay in PLAY.
  - If not frightened: lives -= 1 (never below 0), go to DYING, frightened=0.
- Priority within one cycle:
  - A death crash beats maze_empty.
  - Otherwise maze_empty=1 goes to CLEAR.
  - Score events in that same cycle are still counted.
- DYING:
  - Lasts DYING_TICKS ticks.
  - Then, if lives==0, go to OVER; else pulse respawn and go to READY.
- CLEAR:
  - Lasts READY_TICKS ticks.
  - Then level += 1 (saturating at 15), frightened=0, pulse respawn, go to READY.
- OVER:
  - over=1; score and level hold.
  - A start rising edge (edge-detected) goes to ATTRACT.
  - start held high across the transition does not auto-restart.
- Tick-counter behaviour:
  - The tick counter is cleared on every state entry.
  - A tick on the entry cycle is not counted.
- Outputs are registered; strobes come 1 clk after the causing input.

Decomposition:
- Shared package pac_pkg holds:
  - state encodings (ST_ATTRACT..ST_OVER),
  - default point constants,
  - a 3-bit lives type.
- One natural sub-module: tick_divider (parameter DIV, inputs clk/rst/en/tick/div_sel, output strobe). Instantiate it twice: pacman strobe, and ghost strobe with the frightened doubling.

Test Plan:
- Reset, then start pulse → respawn high for exactly 1 cycle; after 120 ticks state=2, score=0, lives=3.
- In PLAY with PAC_DIV=2, GHOST_DIV=3, 12 ticks → exactly 6 pac_move_en and 4 ghost_move_en pulses; after power_eaten, 12 ticks → 2 ghost_move_en.
- Same-cycle pellet_eaten and power_eaten → score += 60, frightened=1; 360 ticks later frightened=0. Preloading score=65530 and one pellet → score=65535.
- Crash while frightened → score += 200, ghost_home pulse, state stays 2. Crash while not frightened → lives 3→2, state=3, then after 90 ticks state=1.
- Three deaths → state=5, over=1, lives=0. start held high keeps OVER→ATTRACT only once; release and press → READY with score=0.
- maze_empty and non-frightened crash in the same cycle → DYING (not CLEAR). Later maze_empty alone → CLEAR, then level increments 0→1 after 120 ticks. Asserting rst mid-PLAY → all outputs return to their reset values immediately.
